remote_key_queue: RTL and testbench
===================================

Name: remote_key_queue

Overview:
- Controller sitting between the IR remote receiver and the application logic.
- Turns the receiver's multi-cycle Ready/Tecla strobes into single key events.
- Classifies each event as new or auto-repeat from a hold window, and buffers events in a small show-ahead FIFO.
- Hands events to one consumer over a valid/ack handshake; overflow is reported sticky.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- REPEAT_WINDOW, 30400, clocks (100 ms at 304 kHz) within which the same code counts as a repeat.
- CNT_W, 16, timer width; must hold REPEAT_WINDOW.
- DROP_REPEATS, 0, 1 = repeat events are discarded, not queued.

Ports:
- Clock  in  1  system clock, 304 kHz
- Reset  in  1  synchronous, active-high reset
- Ready  in  1  receiver strobe; high for 1..N consecutive cycles per decoded frame
- Tecla  in  8  receiver key code; valid while Ready=1
- KeyAck  in  1  consumer pops the head entry; honoured only when KeyValid=1
- OvfClear  in  1  clears Overflow
- KeyValid  out  1  FIFO non-empty; head entry presented
- KeyCode  out  8  head entry code
- KeyRepeat  out  1  head entry repeat flag
- Count  out  $clog2(DEPTH)+1  entries stored
- Overflow  out  1  sticky: an event was lost because the FIFO was full

Behaviour:
- Clocking and reset:
  - Single clock domain; all state updates on posedge Clock.
  - Reset is synchronous active-high and overrides all other inputs.
- Reset values:
  - KeyValid=0, KeyCode=0, KeyRepeat=0, Count=0, Overflow=0.
  - Internal state: ready_d=0, last_code=0, last_valid=0, timer saturated at REPEAT_WINDOW.
  - Reset mid-operation flushes the FIFO and loses all queued entries.
- Event detection:
  - ready_d is a register of Ready; event = Ready & ~ready_d.
  - Exactly one event per Ready high run, regardless of run length.
  - Tecla is sampled in the event cycle.
  - Ready already high when Reset deasserts produces an event in the first cycle after reset (ready_d=0).
- Repeat classification, in the event cycle:
  - rep = last_valid & (Tecla==last_code) & (timer < REPEAT_WINDOW).
  - On every event, including dropped ones: last_code<=Tecla, last_valid<=1, timer<=0.
  - Otherwise timer increments, saturating at REPEAT_WINDOW with no wrap.
  - A different code always gives rep=0 and restarts the window.
- Push: push_req = event & ~(DROP_REPEATS & rep). The entry is {Tecla, rep}.
- Pop: pop = KeyAck & KeyValid. KeyAck while empty is ignored.
- FIFO: show-ahead, circular pointers wrap modulo DEPTH.
  - KeyValid = (Count != 0); KeyCode/KeyRepeat reflect the head entry, combinationally from storage.
  - Latency: event at edge k into an empty FIFO gives KeyValid=1 after edge k, i.e. one cycle after Ready is first seen high.
- Entry/exit arbitration per cycle:
  - push only, not full: write, Count+1.
  - pop only: advance head, Count-1.
  - push and pop, not empty: both; Count unchanged. This holds when full (slot freed and refilled same edge, no overflow) and when Count=1 (new entry becomes head next cycle).
  - push, full, no pop: entry dropped, Overflow<=1, FIFO unchanged.
- Overflow:
  - Cleared by OvfClear or Reset.
  - Set wins over clear in the same cycle.
- Outputs:
  - Head is stable while KeyValid=1 and KeyAck=0.
  - Consumer may hold KeyAck high continuously to drain one entry per cycle.

Test Plan:
- Reset, then Ready high 3 cycles with Tecla=0x45 -> one push; KeyValid=1 next cycle, KeyCode=0x45, KeyRepeat=0, Count=1; ack -> KeyValid=0, Count=0.
- Tecla=0x45 twice, 1000 clocks apart, then a third time 31000 clocks later -> entries {0x45,0}, {0x45,1}, {0x45,0}; with DROP_REPEATS=1, only two entries, both repeat=0.
- 0x10 then 0x11 within 500 clocks -> both repeat=0.
- DEPTH=4, 5 events 0x01..0x05, no ack -> Count=4, Overflow=1, drain yields 0x01..0x04; OvfClear -> Overflow=0.
- FIFO full, event and KeyAck in the same cycle -> Count stays 4, Overflow stays 0, tail holds the new code.
- Reset asserted with Count=3 and Ready high -> Count=0, KeyValid=0 next cycle; Reset released with Ready still high -> one event pushed, repeat=0.

Source files
------------

// File: rtl/remote_key_queue.sv
// IR remote key queue: turns receiver Ready/Tecla strobes into single key events, tags
// auto-repeats inside a hold window, and buffers them in a show-ahead FIFO for one consumer.
module remote_key_queue #(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned REPEAT_WINDOW = 30400,
  parameter int unsigned CNT_W         = 16,
  parameter bit          DROP_REPEATS  = 1'b0
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     Ready,
  input  logic [7:0]               Tecla,
  input  logic                     KeyAck,
  input  logic                     OvfClear,
  output logic                     KeyValid,
  output logic [7:0]               KeyCode,
  output logic                     KeyRepeat,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CNT_W-1:0] Window    = CNT_W'(REPEAT_WINDOW);
  localparam logic [CntW-1:0]  FullCount = CntW'(DEPTH);

  logic             ready_q;
  logic [7:0]       last_code_q;
  logic             last_valid_q;
  logic [CNT_W-1:0] timer_q;
  logic [8:0]       mem_q [DEPTH];
  logic [PtrW-1:0]  head_q, tail_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             ovf_q;

  logic key_event, is_rep, push_req, fifo_full, fifo_empty, pop, push, ovf_set;

  assign key_event  = Ready & ~ready_q;
  assign is_rep     = last_valid_q & (Tecla == last_code_q) & (timer_q < Window);
  assign push_req   = key_event & ~(DROP_REPEATS & is_rep);
  assign fifo_full  = (count_q == FullCount);
  assign fifo_empty = (count_q == '0);
  assign pop        = KeyAck & ~fifo_empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept the push.
  assign push       = push_req & (~fifo_full | pop);
  assign ovf_set    = push_req & fifo_full & ~pop;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      ready_q      <= 1'b0;
      last_code_q  <= '0;
      last_valid_q <= 1'b0;
      timer_q      <= Window;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      ready_q <= Ready;
      // Dropped repeats still restart the window so a held key keeps repeating.
      if (key_event) begin
        last_code_q  <= Tecla;
        last_valid_q <= 1'b1;
        timer_q      <= '0;
      end else if (timer_q < Window) begin
        timer_q <= timer_q + 1'b1;
      end
      if (push) begin
        mem_q[tail_q] <= {Tecla, is_rep};
        tail_q        <= tail_q + 1'b1;
      end
      if (pop) head_q <= head_q + 1'b1;
      count_q <= count_d;
      if (ovf_set)       ovf_q <= 1'b1;
      else if (OvfClear) ovf_q <= 1'b0;
    end
  end

  assign KeyValid  = ~fifo_empty;
  assign KeyCode   = mem_q[head_q][8:1];
  assign KeyRepeat = mem_q[head_q][0];
  assign Count     = count_q;
  assign Overflow  = ovf_q;

endmodule

// File: tb/tb_remote_key_queue.sv
// Bench for remote_key_queue: two instances (repeats kept / repeats dropped) driven together,
// checked every cycle against a list-based reference model plus directed scenario checks.
module tb_remote_key_queue;

  localparam int unsigned Depth = 4;
  localparam int unsigned Win   = 30400;

  logic       Clock, Reset, Ready, KeyAck, OvfClear;
  logic [7:0] Tecla;
  logic       kv [2];
  logic [7:0] kc [2];
  logic       kr [2];
  logic [2:0] cnt [2];
  logic       ovf [2];

  int n_vec = 0;
  int n_err = 0;

  remote_key_queue #(.DEPTH(Depth), .REPEAT_WINDOW(Win), .CNT_W(16), .DROP_REPEATS(1'b0)) u_keep (
    .Clock(Clock), .Reset(Reset), .Ready(Ready), .Tecla(Tecla), .KeyAck(KeyAck),
    .OvfClear(OvfClear), .KeyValid(kv[0]), .KeyCode(kc[0]), .KeyRepeat(kr[0]),
    .Count(cnt[0]), .Overflow(ovf[0])
  );

  remote_key_queue #(.DEPTH(Depth), .REPEAT_WINDOW(Win), .CNT_W(16), .DROP_REPEATS(1'b1)) u_drop (
    .Clock(Clock), .Reset(Reset), .Ready(Ready), .Tecla(Tecla), .KeyAck(KeyAck),
    .OvfClear(OvfClear), .KeyValid(kv[1]), .KeyCode(kc[1]), .KeyRepeat(kr[1]),
    .Count(cnt[1]), .Overflow(ovf[1])
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Reference model: head of list at index 0, pop shifts the list down.
  bit          m_prev_ready = 1'b0;
  logic [7:0]  m_last_code  = '0;
  bit          m_last_valid = 1'b0;
  int unsigned m_since      = Win;
  logic [8:0]  m_fifo [2][Depth];
  int unsigned m_cnt [2]    = '{0, 0};
  bit          m_ovf [2]    = '{1'b0, 1'b0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit ev, rep, push_req, pop, full;
    if (Reset) begin
      for (int d = 0; d < 2; d++) begin
        m_cnt[d] = 0;
        m_ovf[d] = 1'b0;
      end
      m_last_code  = '0;
      m_last_valid = 1'b0;
      m_since      = Win;
      m_prev_ready = 1'b0;
      return;
    end
    ev  = Ready && !m_prev_ready;
    rep = ev && m_last_valid && (Tecla == m_last_code) && (m_since < Win);
    for (int d = 0; d < 2; d++) begin
      push_req = ev && !((d == 1) && rep);
      pop      = KeyAck && (m_cnt[d] > 0);
      full     = (m_cnt[d] == Depth);
      if (push_req && full && !pop) m_ovf[d] = 1'b1;
      else if (OvfClear)            m_ovf[d] = 1'b0;
      if (pop) begin
        for (int i = 0; i < Depth - 1; i++) m_fifo[d][i] = m_fifo[d][i+1];
        m_cnt[d]--;
      end
      if (push_req && m_cnt[d] < Depth) begin
        m_fifo[d][m_cnt[d]] = {Tecla, rep};
        m_cnt[d]++;
      end
    end
    if (ev) begin
      m_last_code  = Tecla;
      m_last_valid = 1'b1;
      m_since      = 0;
    end else if (m_since < Win) begin
      m_since++;
    end
    m_prev_ready = Ready;
  endtask

  task automatic compare_all();
    string t;
    for (int d = 0; d < 2; d++) begin
      t = (d == 0) ? "keep" : "drop";
      check({t, "_valid"}, 32'(kv[d]), 32'(m_cnt[d] != 0));
      check({t, "_count"}, 32'(cnt[d]), m_cnt[d]);
      check({t, "_ovf"}, 32'(ovf[d]), 32'(m_ovf[d]));
      if (m_cnt[d] != 0) check({t, "_head"}, 32'({kc[d], kr[d]}), 32'(m_fifo[d][0]));
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    model_step();
    @(negedge Clock);
    compare_all();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic press(input logic [7:0] code, input int len);
    Ready = 1'b1;
    Tecla = code;
    idle(len);
    Ready = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  task automatic ack_one();
    KeyAck = 1'b1;
    tick();
    KeyAck = 1'b0;
  endtask

  logic [7:0] codes [3] = '{8'h10, 8'h11, 8'h45};
  logic [7:0] tail_exp [4] = '{8'h02, 8'h03, 8'h04, 8'h77};

  initial begin
    Reset = 1'b1; Ready = 1'b0; Tecla = '0; KeyAck = 1'b0; OvfClear = 1'b0;
    do_reset();
    check("rst_valid", 32'(kv[0]), 0);
    check("rst_code", 32'(kc[0]), 0);
    check("rst_rep", 32'(kr[0]), 0);
    check("rst_count", 32'(cnt[0]), 0);
    check("rst_ovf", 32'(ovf[0]), 0);

    // Three-cycle Ready run -> one event, visible one cycle after Ready first seen.
    Ready = 1'b1; Tecla = 8'h45;
    tick();
    check("tp1_valid", 32'(kv[0]), 1);
    check("tp1_code", 32'(kc[0]), 32'h45);
    check("tp1_rep", 32'(kr[0]), 0);
    idle(2);
    Ready = 1'b0;
    tick();
    check("tp1_count", 32'(cnt[0]), 1);
    ack_one();
    check("tp1_empty", 32'(kv[0]), 0);
    check("tp1_count0", 32'(cnt[0]), 0);

    // Repeat window: 0x45, 0x45 after ~1000 clocks, 0x45 after ~31000 clocks.
    do_reset();
    press(8'h45, 1);
    idle(1000);
    press(8'h45, 2);
    idle(31000);
    press(8'h45, 1);
    check("tp2_keep_cnt", 32'(cnt[0]), 3);
    check("tp2_drop_cnt", 32'(cnt[1]), 2);
    check("tp2_keep0", 32'({kc[0], kr[0]}), 32'({8'h45, 1'b0}));
    check("tp2_drop0", 32'({kc[1], kr[1]}), 32'({8'h45, 1'b0}));
    ack_one();
    check("tp2_keep1", 32'({kc[0], kr[0]}), 32'({8'h45, 1'b1}));
    check("tp2_drop1", 32'({kc[1], kr[1]}), 32'({8'h45, 1'b0}));
    ack_one();
    check("tp2_keep2", 32'({kc[0], kr[0]}), 32'({8'h45, 1'b0}));
    check("tp2_drop_empty", 32'(cnt[1]), 0);
    ack_one();

    // Different codes inside the window are never repeats.
    do_reset();
    press(8'h10, 2);
    idle(300);
    press(8'h11, 1);
    check("tp3_cnt", 32'(cnt[1]), 2);
    check("tp3_head0", 32'({kc[0], kr[0]}), 32'({8'h10, 1'b0}));
    ack_one();
    check("tp3_head1", 32'({kc[0], kr[0]}), 32'({8'h11, 1'b0}));
    ack_one();

    // Overflow: five events into four slots, then drain and clear.
    do_reset();
    for (int i = 1; i <= 5; i++) press(8'(i), 1);
    check("tp4_cnt", 32'(cnt[0]), 4);
    check("tp4_ovf", 32'(ovf[0]), 1);
    for (int i = 1; i <= 4; i++) begin
      check("tp4_drain", 32'(kc[0]), i);
      ack_one();
    end
    check("tp4_ovf_held", 32'(ovf[0]), 1);
    OvfClear = 1'b1;
    tick();
    OvfClear = 1'b0;
    check("tp4_ovf_clr", 32'(ovf[0]), 0);

    // Full FIFO with simultaneous event and ack: no loss, no overflow.
    do_reset();
    for (int i = 1; i <= 4; i++) press(8'(i), 1);
    Ready = 1'b1; Tecla = 8'h77; KeyAck = 1'b1;
    tick();
    Ready = 1'b0; KeyAck = 1'b0;
    check("tp5_cnt", 32'(cnt[0]), 4);
    check("tp5_ovf", 32'(ovf[0]), 0);
    for (int i = 0; i < 4; i++) begin
      check("tp5_drain", 32'(kc[0]), 32'(tail_exp[i]));
      ack_one();
    end

    // Reset mid-operation with Ready held high across the release.
    do_reset();
    for (int i = 1; i <= 3; i++) press(8'(i), 1);
    Ready = 1'b1; Tecla = 8'h22; Reset = 1'b1;
    tick();
    check("tp6_flush_cnt", 32'(cnt[0]), 0);
    check("tp6_flush_valid", 32'(kv[0]), 0);
    Reset = 1'b0;
    tick();
    check("tp6_cnt", 32'(cnt[0]), 1);
    check("tp6_head", 32'({kc[0], kr[0]}), 32'({8'h22, 1'b0}));
    Ready = 1'b0;
    tick();
    ack_one();

    // Randomized traffic: slow consumer first (overflow pressure), then a fast one.
    for (int c = 0; c < 6000; c++) begin
      if ($urandom_range(0, 3) == 0) Ready = ~Ready;
      Tecla    = codes[$urandom_range(0, 2)];
      KeyAck   = (c < 3000) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
      OvfClear = ($urandom_range(0, 19) == 0);
      Reset    = ($urandom_range(0, 499) == 0);
      tick();
    end
    Reset = 1'b0; Ready = 1'b0; KeyAck = 1'b0; OvfClear = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
